// File: rtl/sos_sample_sequencer.sv
// rtl/sos_sample_sequencer.sv - fixed-rate sample sequencer in front of the SOS filter
//
// Purpose:
//   Buffers one input sample and issues it to the filter on every rate tick
//   with a one-cycle trigger. It then waits for the filter to answer and
//   holds the result on a valid/ready output until downstream accepts it.
//   Sticky flags record ticks that found no sample (underrun) and ticks
//   that arrived while a sample was still in flight (overrun).
//
// Optional feature:
//   SOS_SEQ_TIMEOUT_EN - when defined, BUSY gives up after TIMEOUT cycles
//   without filt_done, sets timeout_err and returns to IDLE. When undefined,
//   BUSY waits indefinitely and timeout_err is tied to 0.
//
// Ports:
//   clk, reset              clock (rising edge), asynchronous active-low reset
//   rate_div                sample period minus one, in clk cycles
//   in_data/valid/ready     input sample stream (one-entry buffer)
//   filt_data_in            sample presented to the filter, held between loads
//   filt_sample_trig        one-cycle start pulse to the filter
//   filt_done/data_out      filter completion pulse and its result
//   out_data/valid/ready    filtered sample stream
//   clr_status              clears the sticky flags (a same-cycle set wins)
//   underrun, overrun       sticky status flags
//   timeout_err             sticky filter-timeout flag
module sos_sample_sequencer #(
    parameter int DATA_SIZE = 24,
    parameter int DIV_WIDTH = 16,
    parameter int TIMEOUT   = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] rate_div,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_SIZE-1:0] filt_data_in,
    output logic                 filt_sample_trig,
    input  logic                 filt_done,
    input  logic [DATA_SIZE-1:0] filt_data_out,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 clr_status,
    output logic                 underrun,
    output logic                 overrun,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRIG = 2'd1,
        BUSY = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [DIV_WIDTH-1:0]   cnt;
    logic                   tick;
    logic                   buf_full;
    logic                   buf_full_nx;
    logic [DATA_SIZE-1:0]   buf_data;
    logic                   accept;
    logic                   load;
    logic                   capture;
    logic                   release_out;
    logic                   timeout_hit;
    logic                   to_expire;
    logic                   underrun_set;
    logic                   overrun_set;

    // ">=" rather than "==" so that lowering rate_div below the current
    // count ticks on the next cycle instead of wrapping the whole counter.
    assign tick   = (cnt >= rate_div);
    assign accept = in_valid & in_ready;

    always_comb begin
        state_nx     = state;
        load         = 1'b0;
        capture      = 1'b0;
        release_out  = 1'b0;
        timeout_hit  = 1'b0;
        underrun_set = 1'b0;
        overrun_set  = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nx     = TRIG;
                    load         = buf_full;
                    underrun_set = ~buf_full;
                end
            end
            TRIG: begin
                state_nx    = BUSY;
                overrun_set = tick;
            end
            BUSY: begin
                overrun_set = tick;
                if (filt_done) begin
                    capture  = 1'b1;
                    state_nx = HOLD;
                end else if (to_expire) begin
                    timeout_hit = 1'b1;
                    state_nx    = IDLE;
                end
            end
            HOLD: begin
                overrun_set = tick;
                if (out_ready) begin
                    release_out = 1'b1;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // accept and load never coincide: in_ready is low whenever the buffer is full.
    always_comb begin
        buf_full_nx = buf_full;
        if (accept) begin
            buf_full_nx = 1'b1;
        end else if (load) begin
            buf_full_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_WIDTH'(1);
        end
    end

    // in_ready is registered from the next buffer state, so it is 0 during
    // reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_full <= 1'b0;
            buf_data <= '0;
            in_ready <= 1'b0;
        end else begin
            buf_full <= buf_full_nx;
            in_ready <= ~buf_full_nx;
            if (accept) begin
                buf_data <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_data_in     <= '0;
            filt_sample_trig <= 1'b0;
            out_data         <= '0;
            out_valid        <= 1'b0;
        end else begin
            filt_sample_trig <= (state_nx == TRIG);
            if (load) begin
                filt_data_in <= buf_data;
            end
            if (capture) begin
                out_data  <= filt_data_out;
                out_valid <= 1'b1;
            end else if (release_out) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (underrun_set) begin
                underrun <= 1'b1;
            end else if (clr_status) begin
                underrun <= 1'b0;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (clr_status) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef SOS_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    // to_cnt is 0 in the first BUSY cycle, so the expiry fires in BUSY cycle TIMEOUT.
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (state != BUSY) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign to_expire = (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end else if (clr_status) begin
            timeout_err <= 1'b0;
        end
    end
`else
    assign to_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sos_sample_sequencer.sv
// tb/tb_sos_sample_sequencer.sv - directed bench for sos_sample_sequencer
module tb_sos_sample_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] rate_div = 16'd9;
    logic [23:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] filt_data_in;
    logic        filt_sample_trig;
    logic        filt_done = 1'b0;
    logic [23:0] filt_data_out = '0;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        clr_status = 1'b0;
    logic        underrun;
    logic        overrun;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          trig_cyc[$];
    logic [23:0] trig_dat[$];
    logic        trig_unr[$];
    logic [23:0] out_q[$];

    int          cd = 0;
    logic [23:0] lat = '0;
    bit          filt_en = 1'b1;

    sos_sample_sequencer #(
        .DATA_SIZE(24),
        .DIV_WIDTH(16),
        .TIMEOUT  (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rate_div        (rate_div),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .filt_data_in    (filt_data_in),
        .filt_sample_trig(filt_sample_trig),
        .filt_done       (filt_done),
        .filt_data_out   (filt_data_out),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .clr_status      (clr_status),
        .underrun        (underrun),
        .overrun         (overrun),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Filter model: answers input+1 with filt_done three cycles after the trigger cycle.
    always @(negedge clk) begin
        filt_done = 1'b0;
        if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                filt_done     = 1'b1;
                filt_data_out = lat + 24'd1;
            end
        end
        if (filt_sample_trig && filt_en) begin
            cd  = 3;
            lat = filt_data_in;
        end
    end

    always @(negedge clk) begin
        if (filt_sample_trig) begin
            trig_cyc.push_back(cyc);
            trig_dat.push_back(filt_data_in);
            trig_unr.push_back(underrun);
        end
        if (out_valid && out_ready) begin
            out_q.push_back(out_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        trig_cyc.delete();
        trig_dat.delete();
        trig_unr.delete();
        out_q.delete();
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        clr_status = 1'b0;
        filt_en    = 1'b1;
        cd         = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
    endtask

    // Leaves in_valid high so back-to-back pushes hold it asserted.
    task automatic push(input logic [23:0] d, input string tag);
        int k;
        k = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check(tag, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_trigs(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (trig_cyc.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (trig_cyc.size() < n) check(tag, 32'(trig_cyc.size()), 32'(n));
    endtask

    task automatic wait_outs(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (out_q.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (out_q.size() < n) check(tag, 32'(out_q.size()), 32'(n));
    endtask

    initial begin
        int rel;
        int c0;

        #2 reset = 1'b0;
        #1;
        check("rst_in_ready",  32'(in_ready),         32'd0);
        check("rst_out_valid", 32'(out_valid),        32'd0);
        check("rst_trig",      32'(filt_sample_trig), 32'd0);
        check("rst_flags",     {29'd0, underrun, overrun, timeout_err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rel_in_ready_high", 32'(in_ready), 32'd1);

        // Rate and data path
        rate_div = 16'd9;
        do_reset();
        push(24'h000001, "t1_push1");
        push(24'h000002, "t1_push2");
        push(24'h000003, "t1_push3");
        in_valid = 1'b0;
        wait_outs(3, 100, "t1_outs");
        check("t1_underrun", 32'(underrun), 32'd0);
        check("t1_overrun",  32'(overrun),  32'd0);
        check("t1_out0", 32'(out_q[0]), 32'h000002);
        check("t1_out1", 32'(out_q[1]), 32'h000003);
        check("t1_out2", 32'(out_q[2]), 32'h000004);
        check("t1_gap01", 32'(trig_cyc[1] - trig_cyc[0]), 32'd10);
        check("t1_gap12", 32'(trig_cyc[2] - trig_cyc[1]), 32'd10);

        // Underrun: second tick reissues the held sample
        do_reset();
        push(24'h00ABCD, "t2_push");
        in_valid = 1'b0;
        wait_trigs(2, 40, "t2_trigs");
        check("t2_dat0", 32'(trig_dat[0]), 32'h00ABCD);
        check("t2_dat1", 32'(trig_dat[1]), 32'h00ABCD);
        check("t2_unr0", 32'(trig_unr[0]), 32'd0);
        check("t2_unr1", 32'(trig_unr[1]), 32'd1);
        @(posedge clk);
        #1 clr_status = 1'b1;
        @(posedge clk);
        #1 clr_status = 1'b0;
        check("t2_unr_clr", 32'(underrun), 32'd0);

        // Overrun from output stall
        do_reset();
        out_ready = 1'b0;
        push(24'h000010, "t3_push");
        in_valid = 1'b0;
        wait_trigs(1, 40, "t3_trig");
        repeat (10) @(negedge clk);
        check("t3_valid_mid", 32'(out_valid), 32'd1);
        check("t3_data_mid",  32'(out_data),  32'h000011);
        repeat (20) @(negedge clk);
        check("t3_overrun",  32'(overrun),         32'd1);
        check("t3_trig_cnt", 32'(trig_cyc.size()), 32'd1);
        check("t3_data_end", 32'(out_data),        32'h000011);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_outs(1, 10, "t3_accept");
        check("t3_acc_data", 32'(out_q[0]), 32'h000011);

        // Reset mid-BUSY
        do_reset();
        push(24'h000020, "t4_push");
        in_valid = 1'b0;
        wait_trigs(1, 40, "t4_trig");
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("t4_fdin",  32'(filt_data_in),     32'd0);
        check("t4_trig",  32'(filt_sample_trig), 32'd0);
        check("t4_odata", 32'(out_data),         32'd0);
        check("t4_oval",  32'(out_valid),        32'd0);
        check("t4_inrdy", 32'(in_ready),         32'd0);
        check("t4_flags", {29'd0, underrun, overrun, timeout_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        rel = cyc;
        clear_logs();
        wait_trigs(1, 40, "t4_trig2");
        // Cycles from the release cycle through the first trigger cycle, inclusive.
        check("t4_first_trig", 32'(trig_cyc[0] - rel + 1), 32'd11);
        check("t4_late_done",  32'(out_q.size()),          32'd0);

        // Filter that never answers
        do_reset();
        filt_en = 1'b0;
        push(24'h000040, "t5_push");
        in_valid = 1'b0;
        wait_trigs(1, 40, "t5_trig");
        c0 = trig_cyc[0];
`ifdef SOS_SEQ_TIMEOUT_EN
        repeat (16) @(negedge clk);
        check("t5_to_before", 32'(timeout_err), 32'd0);
        @(negedge clk);
        check("t5_to_after",  32'(timeout_err), 32'd1);
        wait_trigs(2, 40, "t5_trig2");
        check("t5_retrig", 32'(trig_cyc[1] - c0), 32'd20);
`else
        repeat (40) @(negedge clk);
        check("t5_to_off",    32'(timeout_err),      32'd0);
        check("t5_stuck",     32'(trig_cyc.size()),  32'd1);
        check("t5_overrun",   32'(overrun),          32'd1);
        check("t5_no_output", 32'(out_valid),        32'd0);
        check("t5_trig_cyc",  32'(trig_cyc[0] - c0), 32'd0);
`endif

        // Overrun set coinciding with clr_status
        do_reset();
        out_ready = 1'b0;
        push(24'h000050, "t6_push");
        in_valid = 1'b0;
        wait_trigs(1, 40, "t6_trig");
        repeat (9) @(negedge clk);
        check("t6_ovr_pre", 32'(overrun), 32'd0);
        clr_status = 1'b1;
        @(posedge clk);
        #1 clr_status = 1'b0;
        check("t6_ovr_set_wins", 32'(overrun), 32'd1);

        // in_valid held high while the buffer is full
        do_reset();
        push(24'h000061, "t7_push1");
        check("t7_full_rdy", 32'(in_ready), 32'd0);
        push(24'h000062, "t7_push2");
        push(24'h000063, "t7_push3");
        in_valid = 1'b0;
        wait_outs(3, 100, "t7_outs");
        check("t7_dat0", 32'(trig_dat[0]), 32'h000061);
        check("t7_dat1", 32'(trig_dat[1]), 32'h000062);
        check("t7_dat2", 32'(trig_dat[2]), 32'h000063);
        check("t7_out0", 32'(out_q[0]), 32'h000062);
        check("t7_out1", 32'(out_q[1]), 32'h000063);
        check("t7_out2", 32'(out_q[2]), 32'h000064);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sos_sample_sequencer.md
# sos_sample_sequencer

- Sample-rate sequencer that drives the `filter_sos` / `High_pas_top` filter sample interface:
  - Accepts input samples over a valid/ready stream.
  - Issues them to the filter at a fixed programmable rate with a one-cycle `sample_trig`.
  - Waits for `filter_done`, captures the filtered result and presents it on an output valid/ready stream.
- Sits between the audio/ADC front end and the filter chain.

## Interface
- `DATA_SIZE`, 24: sample width, matches the filter.
- `DIV_WIDTH`, 16: width of the sample-period divider.
- `TIMEOUT`, 256: maximum cycles to wait for `filt_done` (used only with `SOS_SEQ_TIMEOUT_EN`).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rate_div`  in  DIV_WIDTH  sample period minus one, in clk cycles.
- `in_data`  in  DATA_SIZE  input sample.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  one-entry input buffer empty.
- `filt_data_in`  out  DATA_SIZE  to filter `data_in`; held stable between loads.
- `filt_sample_trig`  out  1  to filter `sample_trig`; one-cycle pulse.
- `filt_done`  in  1  from filter `filter_done`; one-cycle pulse.
- `filt_data_out`  in  DATA_SIZE  from filter `data_out`; valid in the `filt_done` cycle.
- `out_data`  out  DATA_SIZE  filtered sample.
- `out_valid`  out  1  filtered sample valid.
- `out_ready`  in  1  downstream accepts.
- `clr_status`  in  1  clears the sticky flags.
- `underrun`  out  1  sticky: a tick found the input buffer empty.
- `overrun`  out  1  sticky: a tick arrived while not IDLE.
- `timeout_err`  out  1  sticky: filter failed to respond (macro only; tied 0 otherwise).

## Operation
**Rate counter**
- `cnt` resets to 0.
- `tick` = (`cnt` >= `rate_div`). On `tick`, `cnt` goes to 0; otherwise `cnt` increments.
- `rate_div` may change at any time. If `cnt` is already above the new value, the next cycle ticks.

**Input buffer**
- One entry; `in_ready` = buffer empty (registered).
- A transfer occurs when `in_valid & in_ready`.
- The buffer is freed in the cycle the FSM loads it.
- Accept and load in the same cycle is not possible, because `in_ready` is low while the buffer is full.

**FSM** — IDLE, TRIG, BUSY, HOLD:
- IDLE, on `tick`:
  - Buffer full: `filt_data_in` <= buffer, buffer emptied.
  - Buffer empty: `filt_data_in` keeps its previous value and `underrun` is set.
  - In both cases, go to TRIG.
- TRIG: `filt_sample_trig` = 1 for exactly this cycle, then go to BUSY.
- BUSY: on `filt_done`, `out_data` <= `filt_data_out`, `out_valid` <= 1, go to HOLD.
- HOLD: `out_valid` held until `out_ready` is high, then `out_valid` <= 0 and go to IDLE.
- A `tick` in TRIG, BUSY or HOLD is dropped and sets `overrun`. The counter keeps running.
- A `filt_done` outside BUSY is ignored.

**Status flags**
- `clr_status` clears all sticky flags.
- If a set condition coincides with `clr_status`, the set wins.

**Reset**
- Reset is asserted asynchronously and takes effect mid-operation.
- State returns to IDLE, buffer emptied, `cnt` = 0.
- All outputs go to 0: `filt_data_in`, `filt_sample_trig`, `out_data`, `out_valid`, all flags, and `in_ready`.
- `in_ready` rises to 1 one cycle after reset release.

## Timing
- `tick` in cycle T → `filt_data_in` updated and `filt_sample_trig` high in cycle T+1.
- `filt_done` in cycle D → `out_valid` and `out_data` updated in cycle D+1.
- A non-overrunning sample period requires `rate_div` + 1 >= 2 + filter latency + downstream stall + 1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
**`SOS_SEQ_TIMEOUT_EN` defined**
- BUSY counts cycles from entry.
- If `filt_done` has not arrived when the count reaches `TIMEOUT`:
  - `timeout_err` is set.
  - The FSM returns to IDLE.
  - No output is produced.

**`SOS_SEQ_TIMEOUT_EN` undefined**
- BUSY waits indefinitely.
- `timeout_err` is constant 0 and the timeout counter is not built.

## Test plan
- **Rate and data path.** `rate_div`=9; feed 0x000001, 0x000002, 0x000003; filter model returns input+1 with `filt_done` 3 cycles after trig.
  - `filt_sample_trig` pulses exactly every 10 cycles.
  - `out_data` = 0x000002, 0x000003, 0x000004.
  - `underrun` and `overrun` stay 0.
- **Underrun.** `rate_div`=9; one sample 0x00ABCD, then `in_valid`=0.
  - The second trig reissues 0x00ABCD.
  - `underrun`=1 from that tick on.
  - `clr_status` pulse returns it to 0.
- **Overrun from output stall.** `out_ready`=0 for 30 cycles with `rate_div`=9.
  - Ticks in HOLD set `overrun`.
  - No extra `filt_sample_trig` is issued.
  - `out_data` is unchanged until accepted.
- **Reset mid-BUSY.** Assert `reset` low 2 cycles after trig.
  - All outputs are 0 asynchronously.
  - After release, the first trig occurs `rate_div`+2 cycles later.
  - A late `filt_done` produces no output.
- **Timeout (`SOS_SEQ_TIMEOUT_EN`, `TIMEOUT`=16).** Filter model never asserts `filt_done`.
  - `timeout_err`=1 at BUSY cycle 16.
  - FSM is back in IDLE and the next tick triggers normally.
  - Without the macro, the FSM stays in BUSY and `timeout_err`=0.
- **Simultaneous events.** `clr_status` in the same cycle as an overrun tick.
  - `overrun` reads 1.
  - `in_valid` held high while the buffer is full: `in_ready`=0 and no sample is lost or duplicated.
